// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write-port arbiter: FSM states,
// default timing constants and the HD44780 command codes that need
// the long post-write wait.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  // Default timing in CLOCK_50 cycles (20 ns each).
  localparam int unsigned T_SETUP_DEF      = 2;
  localparam int unsigned T_EN_DEF         = 12;
  localparam int unsigned T_HOLD_DEF       = 1;
  localparam int unsigned T_WAIT_SHORT_DEF = 2000;
  localparam int unsigned T_WAIT_LONG_DEF  = 82000;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear and return-home need the long wait. The controller ignores
  // bit 0 of return-home, so 0x03 is also a home command.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME) ||
                   (data == (LCD_CMD_HOME | 8'h01)));
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter with a done flag; times every non-idle
// state of the LCD arbiter. done is high while the count is zero.
module lcd_delay_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload on state entry, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for the HD44780 write port. Each granted
// byte goes through SETUP, EN PULSE, HOLD and a post-write WAIT whose
// length depends on the byte type.
// Optional feature: define LCD_ARB_LOCK_EN to add lock0/lock1, which
// let the current owner keep the port across consecutive bytes.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP      = T_SETUP_DEF,
  parameter int unsigned T_EN         = T_EN_DEF,
  parameter int unsigned T_HOLD       = T_HOLD_DEF,
  parameter int unsigned T_WAIT_SHORT = T_WAIT_SHORT_DEF,
  parameter int unsigned T_WAIT_LONG  = T_WAIT_LONG_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
`ifdef LCD_ARB_LOCK_EN
  input  logic       lock0,
  input  logic       lock1,
`endif
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       gnt,
  output logic       busy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic       LCD_RW
);

  localparam int unsigned CNT_W = $clog2(T_WAIT_LONG + 1);

  // Counter reload values: a state lasting N cycles loads N-1.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_WAIT_SHORT - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_WAIT_LONG - 1);

  lcd_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;

  logic             grant;
  logic             grant_idx;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;

`ifdef LCD_ARB_LOCK_EN
  logic locked_q, locked_d;
  logic owner_lock;
  assign owner_lock = gnt_q ? lock1 : lock0;
`endif

  lcd_delay_cnt #(
    .W(CNT_W)
  ) u_delay_cnt (
    .clk     (CLOCK_50),
    .rst     (reset),
    .load    (cnt_load),
    .load_val(cnt_val),
    .done    (cnt_done)
  );

  // State and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= '0;
      en_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
`ifdef LCD_ARB_LOCK_EN
      locked_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      en_q     <= en_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
`ifdef LCD_ARB_LOCK_EN
      locked_q <= locked_d;
`endif
    end
  end

  // Arbitration, next state and counter reload on each state entry.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_idx = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          grant     = 1'b1;
          grant_idx = ~last_q;
        end else if (req0 || req1) begin
          grant     = 1'b1;
          grant_idx = req1;
        end
`ifdef LCD_ARB_LOCK_EN
        // A held lock restricts the grant to the owner, even if idle.
        if (locked_q && owner_lock) begin
          grant     = gnt_q ? req1 : req0;
          grant_idx = gnt_q;
        end
`endif
        if (grant) begin
          state_d  = SETUP;
          cnt_load = 1'b1;
          cnt_val  = LD_SETUP;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_d  = PULSE;
          cnt_load = 1'b1;
          cnt_val  = LD_EN;
        end
      end
      PULSE: begin
        if (cnt_done) begin
          state_d  = HOLD;
          cnt_load = 1'b1;
          cnt_val  = LD_HOLD;
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_d  = WAIT;
          cnt_load = 1'b1;
          cnt_val  = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_SHORT;
        end
      end
      WAIT: begin
        if (cnt_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: byte capture on grant, EN follows PULSE.
  always_comb begin
    en_d   = (state_d == PULSE);
    ack0_d = grant && !grant_idx;
    ack1_d = grant && grant_idx;
    gnt_d  = grant ? grant_idx : gnt_q;
    last_d = grant ? grant_idx : last_q;
    rs_d   = rs_q;
    data_d = data_q;
    if (grant) begin
      rs_d   = grant_idx ? rs1 : rs0;
      data_d = grant_idx ? data1 : data0;
    end
`ifdef LCD_ARB_LOCK_EN
    locked_d = locked_q;
    if (state_q == WAIT && cnt_done) begin
      locked_d = owner_lock;
    end else if (state_q == IDLE && !owner_lock) begin
      locked_d = 1'b0;
    end
`endif
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign gnt      = gnt_q;
  assign busy     = (state_q != IDLE);
  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with shortened timing
// (setup 2, EN 3, hold 1, short wait 5, long wait 20 -> 12-cycle
// period for normal bytes, 27 for clear/home).
// Build with LCD_ARB_LOCK_EN defined to include the lock scenario.
module tb_lcd_bus_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       req0, rs0, req1, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, gnt, busy;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_EN, LCD_RW;
`ifdef LCD_ARB_LOCK_EN
  logic       lock0, lock1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  lcd_bus_arbiter #(
    .T_SETUP     (2),
    .T_EN        (3),
    .T_HOLD      (1),
    .T_WAIT_SHORT(5),
    .T_WAIT_LONG (20)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
`ifdef LCD_ARB_LOCK_EN
    .lock0   (lock0),
    .lock1   (lock1),
`endif
    .req0    (req0),
    .rs0     (rs0),
    .data0   (data0),
    .req1    (req1),
    .rs1     (rs1),
    .data1   (data1),
    .ack0    (ack0),
    .ack1    (ack1),
    .gnt     (gnt),
    .busy    (busy),
    .LCD_DATA(LCD_DATA),
    .LCD_RS  (LCD_RS),
    .LCD_EN  (LCD_EN),
    .LCD_RW  (LCD_RW)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"},   LCD_EN,   0);
    check({tag, "_rs"},   LCD_RS,   0);
    check({tag, "_data"}, LCD_DATA, 0);
    check({tag, "_ack0"}, ack0,     0);
    check({tag, "_ack1"}, ack1,     0);
    check({tag, "_gnt"},  gnt,      0);
    check({tag, "_busy"}, busy,     0);
    check({tag, "_rw"},   LCD_RW,   0);
  endtask

  initial begin
    logic exp_idx [4];
    reset = 1'b1;
    req0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
    req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
`ifdef LCD_ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    tick();
    tick();
    check_idle_outputs("rst");
    reset = 1'b0;
    tick();
    check_idle_outputs("post_rst");

    // Single data byte from requester 0.
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
    tick();  // edge k
    check("t1_ack0", ack0, 1);
    check("t1_ack1", ack1, 0);
    check("t1_data", LCD_DATA, 8'h41);
    check("t1_rs", LCD_RS, 1);
    check("t1_gnt", gnt, 0);
    check("t1_busy_k", busy, 1);
    check("t1_en_k", LCD_EN, 0);
    req0 = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check($sformatf("t1_en_k%0d", i), LCD_EN, (i >= 2 && i <= 4) ? 1 : 0);
      check($sformatf("t1_busy_k%0d", i), busy, (i < 11) ? 1 : 0);
      check($sformatf("t1_ack0_k%0d", i), ack0, 0);
    end
    check("t1_data_hold", LCD_DATA, 8'h41);
    check("t1_rs_hold", LCD_RS, 1);

    // Clear command from requester 1 takes the long wait.
    req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
    tick();
    check("t2_ack1", ack1, 1);
    check("t2_ack0", ack0, 0);
    check("t2_gnt", gnt, 1);
    check("t2_data", LCD_DATA, 8'h01);
    check("t2_rs", LCD_RS, 0);
    req1 = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (i == 4) check("t2_en_k4", LCD_EN, 1);
      if (i == 5) check("t2_en_k5", LCD_EN, 0);
      if (i == 11) check("t2_busy_k11", busy, 1);
      if (i == 25) check("t2_busy_k25", busy, 1);
      if (i == 26) check("t2_busy_k26", busy, 0);
    end

    // Both requesting: alternate starting with 0 (last grant was 1).
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h30;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h31;
    exp_idx = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 48; t++) begin
      tick();
      if (t % 12 == 0) begin
        check($sformatf("t3_ack0_%0d", t), ack0, exp_idx[t/12] ? 0 : 1);
        check($sformatf("t3_ack1_%0d", t), ack1, exp_idx[t/12] ? 1 : 0);
        check($sformatf("t3_gnt_%0d", t), gnt, exp_idx[t/12]);
        check($sformatf("t3_data_%0d", t), LCD_DATA, exp_idx[t/12] ? 8'h31 : 8'h30);
      end else begin
        check($sformatf("t3_noack_%0d", t), {ack1, ack0}, 0);
      end
      if (t == 47) begin
        check("t3_busy_end", busy, 0);
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    tick();
    check("t3_no_extra", {ack1, ack0, busy}, 0);

    // req0 held alone: back-to-back every 12 cycles.
    req0 = 1'b1; data0 = 8'h5a;
    for (int t = 0; t < 36; t++) begin
      tick();
      check($sformatf("t4_ack0_%0d", t), ack0, (t % 12 == 0) ? 1 : 0);
      check($sformatf("t4_ack1_%0d", t), ack1, 0);
      if (t == 35) req0 = 1'b0;
    end
    tick();
    check("t4_no_extra", {ack0, busy}, 0);

`ifdef LCD_ARB_LOCK_EN
    // Owner lock: three bytes to 0 despite req1, then 1.
    req0 = 1'b1; lock0 = 1'b1; data0 = 8'h80; rs0 = 1'b0;
    req1 = 1'b1; data1 = 8'h62;
    exp_idx = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 48; t++) begin
      tick();
      if (t % 12 == 0) begin
        check($sformatf("t5_ack0_%0d", t), ack0, exp_idx[t/12] ? 0 : 1);
        check($sformatf("t5_ack1_%0d", t), ack1, exp_idx[t/12] ? 1 : 0);
      end
      if (t == 24) lock0 = 1'b0;
      if (t == 47) begin req0 = 1'b0; req1 = 1'b0; end
    end
    tick();
    check("t5_no_extra", {ack1, ack0, busy}, 0);
`endif

    // Reset during the EN pulse clears everything asynchronously.
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h55;
    tick();
    check("t6_ack0", ack0, 1);
    req0 = 1'b0;
    tick();
    tick();
    tick();
    check("t6_en_before", LCD_EN, 1);
    reset = 1'b1;
    #1;
    check_idle_outputs("t6_async");
    tick();
    reset = 1'b0;
    tick();
    check("t6_still_idle", busy, 0);
    // Last-grant register is back at 1, so requester 0 wins the tie.
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h33;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h44;
    tick();
    check("t6_regrant_ack0", ack0, 1);
    check("t6_regrant_ack1", ack1, 0);
    check("t6_regrant_data", LCD_DATA, 8'h33);
    check("t6_regrant_busy", busy, 1);
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 1; i <= 11; i++) tick();
    check("t6_done", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the single HD44780 LCD write port between two byte-level requesters: requester 0 is the time-display refresher and requester 1 is the message/status writer. Each accepted byte is driven through RS/DATA setup, an EN pulse, hold, and a post-write busy wait. The post-write wait is chosen from the byte type. The block sits between the LCD control logic and the board LCD pins and removes the need for requesters to own EN timing.

## Interface
Parameters:
- T_SETUP, 2: cycles RS/DATA are stable before EN rises (≥40 ns at 50 MHz).
- T_EN, 12: EN high cycles (≥230 ns).
- T_HOLD, 1: cycles RS/DATA are held after EN falls.
- T_WAIT_SHORT, 2000: post-write wait for normal bytes (40 µs).
- T_WAIT_LONG, 82000: post-write wait for clear/home (1.64 ms).

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request; held high until the matching ack.
- rs0 / rs1  in  1  RS for the offered byte (0 = command, 1 = data).
- data0 / data1  in  8  offered byte.
- ack0 / ack1  out  1  one-cycle pulse when the byte is captured.
- gnt  out  1  index of the requester owning the current transfer.
- busy  out  1  high in every state except IDLE.
- LCD_DATA  out  8  registered LCD data bus.
- LCD_RS  out  1  registered register-select.
- LCD_EN  out  1  registered enable strobe.
- LCD_RW  out  1  constant 0; the block only writes.
- lock0 / lock1  in  1  only present with LCD_ARB_LOCK_EN.

## Operation
- States: IDLE → SETUP → PULSE → HOLD → WAIT → IDLE.
- IDLE, no request: remain in IDLE.
- IDLE, one request: grant that requester.
- IDLE, both requesting: round-robin, granting the requester that was not granted last. The last-grant register resets to 1, so requester 0 wins the first tie.
- On grant: latch rs/data into LCD_RS/LCD_DATA, set gnt, pulse the matching ack for one cycle, enter SETUP.
- SETUP lasts T_SETUP cycles. PULSE lasts T_EN cycles with LCD_EN=1. HOLD lasts T_HOLD cycles. WAIT lasts T_WAIT cycles. Then return to IDLE.
- T_WAIT = T_WAIT_LONG when the latched rs=0 and data ∈ {0x01, 0x02, 0x03}; T_WAIT_SHORT otherwise.
- LCD_RS and LCD_DATA stay unchanged from grant until the next grant.
- Requests are ignored outside IDLE. A requester that keeps req high after its ack is treated as offering a new byte.
- Dropping req before ack: the byte is not written and nothing is flagged.
- Duration counter: a single down-counter sized $clog2(T_WAIT_LONG+1), reloaded at each state entry. Each parameter must be ≥1.

## Timing
- Reset values: LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, ack0=ack1=0, gnt=0, busy=0, LCD_RW=0, state IDLE.
- Grant latency: req sampled high in IDLE at edge k → ack, LCD_RS/LCD_DATA valid, and busy=1 from edge k.
- LCD_EN rises at edge k+T_SETUP and falls at edge k+T_SETUP+T_EN.
- busy falls at edge k+T_SETUP+T_EN+T_HOLD+T_WAIT.
- Earliest next grant is one edge after busy falls. Per-byte period = T_SETUP+T_EN+T_HOLD+T_WAIT+1 cycles.
- Reset mid-transfer: all outputs return to their reset values asynchronously, including EN dropping mid-pulse. The truncated write is not retried; re-initialising the LCD is the requesters' responsibility.

## Configuration
- LCD_ARB_LOCK_EN defined:
  - lock0/lock1 ports exist.
  - If the owner holds its lock high when WAIT ends, the next IDLE arbitration grants only that requester, even when the other is requesting.
  - While lock is held and the owner's req is low, the block stays in IDLE waiting for the owner.
  - When lock drops, normal round-robin resumes.
  - Purpose: an atomic cursor-set followed by a string.
- LCD_ARB_LOCK_EN undefined: the ports are absent and arbitration is pure per-byte round-robin.

## Structure
- Shared package lcd_pkg holds:
  - state enum (IDLE, SETUP, PULSE, HOLD, WAIT);
  - default timing constants;
  - command codes LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02.
- One natural sub-module, lcd_delay_cnt: a loadable down-counter with a done flag, used for all four timed states.

## Test plan
Use T_SETUP=2, T_EN=3, T_HOLD=1, T_WAIT_SHORT=5, T_WAIT_LONG=20 for speed.
- req0 with rs0=1, data0=0x41 → ack0 at k, LCD_DATA=0x41, LCD_RS=1, EN high for edges k+2..k+4, busy low at k+11.
- req1 with rs1=0, data1=0x01 → long wait; busy falls at k+26; gnt=1.
- req0 and req1 asserted together and held for 4 bytes → grant order 0,1,0,1; period 12 cycles each.
- req0 held continuously, req1 idle → back-to-back transfers, ack0 every 12 cycles.
- LCD_ARB_LOCK_EN: lock0 high for 3 bytes with req1 pending → three grants to 0, then 1 once lock0 drops.
- reset asserted during PULSE → LCD_EN=0 and busy=0 immediately; after release, a new req0 is granted normally.
